node_accum: RTL and testbench

NODE_ACCUM -- requirements
Module: node_accum

---
 rtl/node_accum_if.sv | 24 ++
 rtl/node_accum.sv | 94 +++++++++
 tb/tb_node_accum.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/node_accum_if.sv
// node_accum_if: handshake and data bundle between the MAC stage, node_accum and the activation sink
interface node_accum_if #(
    parameter int OUT_W = 8
);
    logic              start;
    logic signed [15:0] bias_in;
    logic [19:0]       sum_in;
    logic              sum_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  act_out;
    logic              act_valid;
    logic              act_sat;
    logic              busy;

    modport master (
        output start, bias_in, sum_in, sum_valid, out_ready,
        input  act_out, act_valid, act_sat, busy
    );

    modport slave (
        input  start, bias_in, sum_in, sum_valid, out_ready,
        output act_out, act_valid, act_sat, busy
    );
endinterface

// File: rtl/node_accum.sv
// node_accum: accumulates per-neuron partial sums, adds bias, applies ReLU, shift and saturation
module node_accum #(
    parameter int NUM_CHUNKS = 49,
    parameter int SHIFT      = 8,
    parameter int OUT_W      = 8
) (
    input logic         clk,
    input logic         rst_n,
    node_accum_if.slave bus
);
    localparam int CW = $clog2(NUM_CHUNKS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;

    state_t             state_q, state_d;
    logic [25:0]        acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [15:0] bias_q, bias_d;
    logic [OUT_W-1:0]   act_q, act_d;
    logic               sat_q, sat_d;
    logic               valid_q, valid_d;

    logic signed [26:0] total;
    logic [25:0]        relu;
    logic [25:0]        shifted;
    logic               sat;

    // The accumulator is always non-negative, so after ReLU a logical shift equals the arithmetic one
    assign total   = $signed({1'b0, acc_q}) + $signed({{11{bias_q[15]}}, bias_q});
    assign relu    = total[26] ? '0 : total[25:0];
    assign shifted = relu >> SHIFT;
    assign sat     = (shifted >> OUT_W) != '0;

    assign bus.act_out   = act_q;
    assign bus.act_sat   = sat_q;
    assign bus.act_valid = valid_q;
    assign bus.busy      = state_q != IDLE;

    // State and datapath registers; reset aborts any neuron in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            bias_q  <= '0;
            act_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
            act_q   <= act_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; start and sum_valid are only honoured in IDLE and ACCUM respectively
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        act_d   = act_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
                bias_d  = bus.bias_in;
            end
            ACCUM: if (bus.sum_valid) begin
                acc_d   = acc_q + {6'b0, bus.sum_in};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(NUM_CHUNKS - 1) ? FINAL : ACCUM;
            end
            FINAL: begin
                act_d   = sat ? '1 : shifted[OUT_W-1:0];
                sat_d   = sat;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: if (bus.out_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_node_accum.sv
// tb_node_accum: directed checks of accumulation, ReLU, saturation, backpressure and reset abort
module tb_node_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    node_accum_if #(.OUT_W(8)) bus ();

    node_accum #(.NUM_CHUNKS(49), .SHIFT(8), .OUT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_neuron(input logic signed [15:0] b);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.bias_in = b;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.bias_in = 16'sd0;
    endtask

    // Presents n sums; each is accepted on the next rising edge, followed by 0..gmax idle cycles
    task automatic feed(input int n, input logic [19:0] v, input int gmax);
        for (int i = 0; i < n; i++) begin
            bus.sum_valid = 1'b1;
            bus.sum_in    = v;
            @(negedge clk);
            bus.sum_valid = 1'b0;
            bus.sum_in    = '0;
            if (i != n - 1)
                repeat ($urandom_range(gmax, 0)) @(negedge clk);
        end
    endtask

    // Checks latency and result, then completes the handshake
    task automatic expect_result(input string tag, input logic [7:0] act, input logic sat);
        check({tag, " valid_in_final"}, bus.act_valid, 1'b0);
        check({tag, " busy_in_final"}, bus.busy, 1'b1);
        @(negedge clk);
        check({tag, " valid"}, bus.act_valid, 1'b1);
        check({tag, " act_out"}, bus.act_out, act);
        check({tag, " act_sat"}, bus.act_sat, sat);
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " valid_after_hs"}, bus.act_valid, 1'b0);
        check({tag, " busy_after_hs"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.bias_in   = 16'sd0;
        bus.sum_in    = '0;
        bus.sum_valid = 1'b0;
        bus.out_ready = 1'b0;

        #1;
        check("reset act_out", bus.act_out, 8'd0);
        check("reset act_valid", bus.act_valid, 1'b0);
        check("reset act_sat", bus.act_sat, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Nominal: 49 x 1000 = 49000, >>8 = 191
        start_neuron(16'sd0);
        check("nominal busy", bus.busy, 1'b1);
        feed(49, 20'd1000, 0);
        expect_result("nominal", 8'd191, 1'b0);
        handshake("nominal");
        check("idle keeps act_out", bus.act_out, 8'd191);

        // ReLU: -5000 + 4900 = -100 clamps to 0
        start_neuron(-16'sd5000);
        feed(49, 20'd100, 0);
        expect_result("relu", 8'd0, 1'b0);
        handshake("relu");

        // Saturation: 51380175 >> 8 = 200703 clips to 255
        start_neuron(16'sd0);
        feed(49, 20'hFFFFF, 0);
        expect_result("sat", 8'd255, 1'b1);

        // Backpressure with start and sum_valid asserted while OUT waits
        bus.start     = 1'b1;
        bus.bias_in   = 16'sd100;
        bus.sum_valid = 1'b1;
        bus.sum_in    = 20'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp act_out", bus.act_out, 8'd255);
            check("bp act_sat", bus.act_sat, 1'b1);
            check("bp valid", bus.act_valid, 1'b1);
        end
        bus.sum_valid = 1'b0;
        handshake("bp");
        bus.start = 1'b0;
        @(negedge clk);
        check("start during hs ignored", bus.busy, 1'b0);

        // start and sum_valid together in IDLE: the sum must not be accumulated
        @(negedge clk);
        bus.start     = 1'b1;
        bus.sum_valid = 1'b1;
        bus.sum_in    = 20'hFFFFF;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.sum_valid = 1'b0;
        feed(49, 20'd1000, 0);
        expect_result("start_and_sum", 8'd191, 1'b0);
        handshake("start_and_sum");

        // Abort mid-accumulation with an asynchronous reset between edges
        start_neuron(16'sd300);
        feed(20, 20'hFFFFF, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", bus.busy, 1'b0);
        check("abort act_out", bus.act_out, 8'd0);
        check("abort valid", bus.act_valid, 1'b0);
        check("abort sat", bus.act_sat, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start_neuron(16'sd0);
        feed(49, 20'd1000, 3);
        expect_result("after_abort", 8'd191, 1'b0);
        handshake("after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
